// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: iterative AES InvMixColumns engine (decrypt path).
// Accepts a 128-bit state over in_valid/in_ready. It transforms COLS_PER_CYCLE
// columns per busy cycle in place, then presents the result over
// out_valid/out_ready.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_ready  input handshake
//   data_in[127:0]      input state, column c = data_in[127-32c -: 32], row 0 = MSB
//   out_valid, out_ready output handshake
//   data_out[127:0]     transformed state, same layout as data_in
module inv_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int unsigned N_COLS   = 4;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned STATE_W  = 128;
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(COLS_PER_CYCLE);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - COLS_PER_CYCLE);

  // Only 1, 2 or 4 columns per cycle tile the four-column state evenly.
  if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [COL_W-1:0]    col, col_next;
  logic [STATE_W-1:0]  work, work_next;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] x);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x); x4 = xtime(x2); x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One column through the inverse mix matrix; a0 is the MSB byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    {a0, a1, a2, a3} = c;
    r0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
    r1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
    r2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
    r3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
    return {r0, r1, r2, r3};
  endfunction

  // State, column counter and working register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      work  <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      work  <= work_next;
    end
  end

  // Next-state logic and in-place column update.
  always_comb begin
    logic [COL_W-1:0] idx;
    logic [6:0]       lo;
    state_next = state;
    col_next   = col;
    work_next  = work;
    idx        = '0;
    lo         = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_next  = data_in;
          col_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
          idx = col + COL_W'(k);
          // Column idx starts at bit 32*(3-idx); 3-idx is ~idx in two bits.
          lo  = {~idx, 5'd0};
          work_next[lo +: 32] = inv_mix_col(work[lo +: 32]);
        end
        col_next = col + COL_STEP;
        if (col == LAST_COL) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs decode directly from registered state.
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign data_out  = work;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Testbench for inv_mix_columns_seq. Three instances cover COLS_PER_CYCLE = 1, 2, 4.
// Expected results come from a generic GF(2^8) matrix model.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n     [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] data_in   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] data_out  [3];

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .data_in   (data_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Schoolbook carry-less product followed by polynomial reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix product: row r, column j uses coef[(j - r) mod 4].
  function automatic logic [127:0] mat_state(input logic [127:0] s, input logic [31:0] coefs);
    logic [127:0] res;
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   acc;
    for (int i = 0; i < 4; i++) coef[i] = coefs[31 - 8*i -: 8];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j - r + 4) % 4], a[j]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    return mat_state(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] ref_fwd(input logic [127:0] s);
    return mat_state(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block through instance u. stall = cycles out_ready is held low in DONE.
  task automatic run_xfer(input int u, input logic [127:0] din, input logic [127:0] exp,
                          input int stall, output int unsigned t_acc);
    int n;
    int lat;
    logic [127:0] held;
    n = 0;
    out_ready[u] = (stall == 0);
    while (!in_ready[u] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("u%0d in_ready_before_accept", u), 128'(in_ready[u]), 128'(1));
    in_valid[u] = 1'b1;
    data_in[u]  = din;
    @(posedge clk); #1;
    t_acc = cyc;
    // Inputs toggled while busy must be ignored.
    in_valid[u] = 1'(($urandom) & 1);
    data_in[u]  = rand128();
    lat = 0;
    while (!out_valid[u] && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (!out_valid[u]) check($sformatf("u%0d in_ready_busy", u), 128'(in_ready[u]), 128'(0));
    end
    in_valid[u] = 1'b0;
    check($sformatf("u%0d latency", u), 128'(lat), 128'(4 >> u));
    check($sformatf("u%0d data", u), data_out[u], exp);
    held = data_out[u];
    for (int s = 0; s < stall; s++) begin
      in_valid[u] = 1'(($urandom) & 1);
      data_in[u]  = rand128();
      @(posedge clk); #1;
      check($sformatf("u%0d hold_valid", u), 128'(out_valid[u]), 128'(1));
      check($sformatf("u%0d hold_data", u), data_out[u], held);
      check($sformatf("u%0d hold_in_ready", u), 128'(in_ready[u]), 128'(0));
    end
    if (stall > 0) in_valid[u] = 1'b1;  // present on the handshake edge: must not be taken
    out_ready[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    check($sformatf("u%0d drain_valid", u), 128'(out_valid[u]), 128'(0));
    check($sformatf("u%0d drain_in_ready", u), 128'(in_ready[u]), 128'(1));
  endtask

  // Reset asserted at BUSY cycle 2, then a fresh block must come out clean.
  task automatic run_abort(input int u);
    logic [127:0] d;
    int unsigned t;
    out_ready[u] = 1'b1;
    in_valid[u]  = 1'b1;
    data_in[u]   = rand128();
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    @(posedge clk); #1;
    rst_n[u] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("u%0d abort_valid", u), 128'(out_valid[u]), 128'(0));
    check($sformatf("u%0d abort_data", u), data_out[u], 128'(0));
    check($sformatf("u%0d abort_in_ready", u), 128'(in_ready[u]), 128'(0));
    rst_n[u] = 1'b1;
    #1;
    check($sformatf("u%0d abort_release_ready", u), 128'(in_ready[u]), 128'(1));
    d = rand128();
    run_xfer(u, d, ref_inv(d), 0, t);
  endtask

  localparam logic [127:0] KV_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] KV_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] BB_IN  = 128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] BB_OUT = 128'hd4d4d4d5_2d26314c_d4d4d4d5_2d26314c;
  localparam logic [127:0] ONES   = 128'h01010101_01010101_01010101_01010101;

  initial begin
    int unsigned t0, t1;
    logic [127:0] x;
    for (int u = 0; u < 3; u++) begin
      rst_n[u]     = 1'b0;
      in_valid[u]  = 1'b1;
      data_in[u]   = rand128();
      out_ready[u] = 1'b0;
    end

    // Reset held for three edges with in_valid high.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      for (int u = 0; u < 3; u++) begin
        check($sformatf("u%0d rst_in_ready", u), 128'(in_ready[u]), 128'(0));
        check($sformatf("u%0d rst_out_valid", u), 128'(out_valid[u]), 128'(0));
        check($sformatf("u%0d rst_data_out", u), data_out[u], 128'(0));
      end
    end
    for (int u = 0; u < 3; u++) begin
      rst_n[u]    = 1'b1;
      in_valid[u] = 1'b0;
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("u%0d post_rst_in_ready", u), 128'(in_ready[u]), 128'(1));
      check($sformatf("u%0d post_rst_out_valid", u), 128'(out_valid[u]), 128'(0));
    end

    // Known vector on every width; backpressure with toggled inputs on width 1.
    run_xfer(0, KV_IN, KV_OUT, 10, t0);
    run_xfer(1, KV_IN, KV_OUT, 0, t0);
    run_xfer(2, KV_IN, KV_OUT, 3, t0);

    // Back-to-back streaming; acceptances spaced N+2 apart.
    for (int u = 0; u < 3; u++) begin
      run_xfer(u, BB_IN, BB_OUT, 0, t0);
      run_xfer(u, ONES, ONES, 0, t1);
      check($sformatf("u%0d b2b_spacing", u), 128'(t1 - t0), 128'((4 >> u) + 2));
    end

    run_abort(0);
    run_abort(1);

    // Random states against the model.
    for (int i = 0; i < 60; i++) begin
      x = rand128();
      run_xfer(i % 3, x, ref_inv(x), int'($urandom_range(0, 2)), t0);
    end

    // Round trip: feeding MixColumns(x) must give back x.
    for (int i = 0; i < 1000; i++) begin
      x = rand128();
      run_xfer(i % 3, ref_fwd(x), x, 0, t0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
